// File: rtl/jstk_pkg.sv
// jstk_pkg: shared PmodJSTK frame layout, command prefix and FSM encodings
package jstk_pkg;
  localparam int         FRAME_BITS = 40;
  localparam int         CNT_W      = 6;
  localparam logic [5:0] CMD_PREFIX = 6'b100000;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam int         BYTE_X_LO  = 0;
  localparam int         BYTE_X_HI  = 1;
  localparam int         BYTE_Y_LO  = 2;
  localparam int         BYTE_Y_HI  = 3;
  localparam int         BYTE_BTN   = 4;
  // Pack a frame with byte 0 in the top bits so it leaves MSB first
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1-8*BYTE_X_LO -: 8] = x[7:0];
    f[FRAME_BITS-1-8*BYTE_X_HI -: 8] = {6'b0, x[9:8]};
    f[FRAME_BITS-1-8*BYTE_Y_LO -: 8] = y[7:0];
    f[FRAME_BITS-1-8*BYTE_Y_HI -: 8] = {6'b0, y[9:8]};
    f[FRAME_BITS-1-8*BYTE_BTN  -: 8] = {5'b0, b};
    return f;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   vld_q, vld_d;
  // Shift the input through the chain; vld marks when every stage holds a real post-reset sample
  always_comb begin
    sync_d = STAGES'({sync_q, d});
    prev_d = sync_q[STAGES-1];
    vld_d  = (STAGES+1)'({vld_q, 1'b1});
  end
  // Chain registers, preset to the idle level of the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end
  assign rise = vld_q[STAGES] & sync_q[STAGES-1] & ~prev_q;
  assign fall = vld_q[STAGES] & ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave that emulates a PmodJSTK joystick frame
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_Pos,
  input  logic [9:0] Y_Pos,
  input  logic [2:0] Buttons,
  output logic [1:0] LED,
  output logic       Busy,
  output logic       Frame_Done,
  output logic       Frame_Abort
);
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nx;
  logic [7:0]             rx_q, rx_d, rx_nx;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [1:0]             led_q, led_d;
  logic                   done_q, done_d, abort_q, abort_d, dec_q, dec_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(Clk), .rst_n(Reset), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(Clk), .rst_n(Reset), .d(SS), .rise(ss_rise), .fall(ss_fall)
  );

  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rx_nx  = {rx_q[6:0], mosi_s};
  assign cnt_nx = cnt_q + 1'b1;

  // Frame FSM: snapshot on SS fall, sample on SCLK rise, shift on SCLK fall; SS edge wins over a coincident SCLK rise
  always_comb begin
    mosi_d  = SYNC_STAGES'({mosi_q, MOSI});
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    dec_d   = 1'b0;
    led_d   = (dec_q && rx_q[7:2] == CMD_PREFIX) ? rx_q[1:0] : led_q;
    if (state_q == ST_IDLE) begin
      if (ss_fall) begin
        tx_d    = build_frame(X_Pos, Y_Pos, Buttons);
        state_d = ST_SHIFT;
        cnt_d   = sclk_rise ? CNT_W'(1) : '0;
        rx_d    = sclk_rise ? {7'b0, mosi_s} : '0;
      end
    end else if (state_q == ST_SHIFT) begin
      if (ss_rise) begin
        state_d = ST_IDLE;
        abort_d = 1'b1;
      end else if (sclk_rise) begin
        rx_d    = rx_nx;
        cnt_d   = cnt_nx;
        dec_d   = cnt_nx == CNT_W'(8);
        done_d  = cnt_nx == CNT_W'(FRAME_BITS);
        state_d = done_d ? ST_HOLD : ST_SHIFT;
      end else if (sclk_fall) begin
        tx_d = tx_q << 1;
      end
    end else if (ss_rise) begin
      state_d = ST_IDLE;
    end
  end

  // State registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mosi_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      led_q   <= 2'b00;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      mosi_q  <= mosi_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      led_q   <= led_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      dec_q   <= dec_d;
    end
  end

  assign MISO        = (state_q == ST_SHIFT) & tx_q[FRAME_BITS-1];
  assign Busy        = state_q != ST_IDLE;
  assign LED         = led_q;
  assign Frame_Done  = done_q;
  assign Frame_Abort = abort_q;
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed SPI master scenarios for the joystick responder
module tb_jstk_spi_responder;
  localparam int HP = 8;
  logic       Clk = 1'b0, Reset = 1'b0, SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0;
  logic [9:0] X_Pos = '0, Y_Pos = '0;
  logic [2:0] Buttons = '0;
  logic       MISO, Busy, Frame_Done, Frame_Abort;
  logic [1:0] LED;
  int         checks = 0, errors = 0, n_done = 0, n_abort = 0;
  int         d0, a0;
  logic [47:0] r1, r2;

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .X_Pos(X_Pos), .Y_Pos(Y_Pos), .Buttons(Buttons), .LED(LED), .Busy(Busy),
    .Frame_Done(Frame_Done), .Frame_Abort(Frame_Abort)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Frame_Done) n_done++;
    if (Frame_Abort) n_abort++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input int n, input logic [47:0] tx, output logic [47:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = tx[47-i];
      wait_clk(HP);
      rx = {rx[46:0], MISO};
      SCLK = 1'b1;
      wait_clk(HP);
      SCLK = 1'b0;
    end
  endtask

  task automatic end_frame();
    wait_clk(HP);
    SS = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_miso", 64'(MISO), 0);
    chk("rst_led", 64'(LED), 0);
    chk("rst_busy", 64'(Busy), 0);
    chk("rst_done", 64'(Frame_Done), 0);
    chk("rst_abort", 64'(Frame_Abort), 0);
    Reset = 1'b1;
    wait_clk(10);

    X_Pos = 10'h2A5; Y_Pos = 10'h1C3; Buttons = 3'b101;
    d0 = n_done; a0 = n_abort;
    SS = 1'b0;
    wait_clk(3);
    chk("s1_miso_first", 64'(MISO), 1);
    chk("s1_busy", 64'(Busy), 1);
    wait_clk(5);
    shift_bits(40, {8'h83, 40'h0}, r1);
    chk("s1_data", 64'(r1[39:0]), 64'h A502C30105);
    chk("s1_led", 64'(LED), 2'b11);
    chk("s1_done", 64'(n_done - d0), 1);
    chk("s1_busy_hold", 64'(Busy), 1);
    end_frame();
    chk("s1_busy_end", 64'(Busy), 0);
    chk("s1_miso_idle", 64'(MISO), 0);
    chk("s1_abort", 64'(n_abort - a0), 0);

    X_Pos = 10'h15A; Y_Pos = 10'h0F0; Buttons = 3'b010;
    d0 = n_done;
    SS = 1'b0;
    wait_clk(8);
    shift_bits(20, {8'h47, 40'h0}, r1);
    X_Pos = 10'h000; Y_Pos = 10'h3FF; Buttons = 3'b111;
    shift_bits(20, 48'h0, r2);
    chk("s2_data", 64'({r1[19:0], r2[19:0]}), 64'h5A01F00002);
    chk("s2_led", 64'(LED), 2'b11);
    chk("s2_done", 64'(n_done - d0), 1);
    end_frame();

    d0 = n_done; a0 = n_abort;
    SS = 1'b0;
    wait_clk(8);
    shift_bits(12, {8'h81, 40'h0}, r1);
    end_frame();
    chk("s3_abort", 64'(n_abort - a0), 1);
    chk("s3_led", 64'(LED), 2'b01);
    chk("s3_done", 64'(n_done - d0), 0);
    chk("s3_miso", 64'(MISO), 0);
    chk("s3_busy", 64'(Busy), 0);

    d0 = n_done; a0 = n_abort;
    SS = 1'b0;
    wait_clk(8);
    shift_bits(5, {8'h83, 40'h0}, r1);
    end_frame();
    chk("s4_abort", 64'(n_abort - a0), 1);
    chk("s4_led", 64'(LED), 2'b01);
    chk("s4_done", 64'(n_done - d0), 0);

    X_Pos = 10'h2A5; Y_Pos = 10'h1C3; Buttons = 3'b101;
    d0 = n_done; a0 = n_abort;
    SS = 1'b0;
    wait_clk(8);
    shift_bits(44, {8'h83, 40'h0}, r1);
    chk("s5_data", 64'(r1[43:0]), 64'h A502C301050);
    chk("s5_done", 64'(n_done - d0), 1);
    chk("s5_miso_hold", 64'(MISO), 0);
    chk("s5_busy_hold", 64'(Busy), 1);
    chk("s5_led", 64'(LED), 2'b11);
    end_frame();
    chk("s5_busy_end", 64'(Busy), 0);
    chk("s5_done_total", 64'(n_done - d0), 1);
    chk("s5_abort", 64'(n_abort - a0), 0);

    d0 = n_done; a0 = n_abort;
    SS = 1'b0;
    wait_clk(8);
    shift_bits(20, {8'h81, 40'h0}, r1);
    Reset = 1'b0;
    #1;
    chk("s6_rst_led", 64'(LED), 0);
    chk("s6_rst_busy", 64'(Busy), 0);
    chk("s6_rst_miso", 64'(MISO), 0);
    wait_clk(4);
    Reset = 1'b1;
    wait_clk(20);
    chk("s6_no_start", 64'(Busy), 0);
    shift_bits(8, {8'h83, 40'h0}, r1);
    chk("s6_idle_busy", 64'(Busy), 0);
    chk("s6_idle_led", 64'(LED), 0);
    chk("s6_idle_miso", 64'(r1[7:0]), 0);
    end_frame();
    chk("s6_abort", 64'(n_abort - a0), 0);
    chk("s6_done", 64'(n_done - d0), 0);
    SS = 1'b0;
    wait_clk(8);
    shift_bits(40, {8'h83, 40'h0}, r1);
    chk("s6_data", 64'(r1[39:0]), 64'h A502C30105);
    chk("s6_led", 64'(LED), 2'b11);
    chk("s6_done_new", 64'(n_done - d0), 1);
    end_frame();
    chk("s6_busy_end", 64'(Busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
